encode_string_stream: RTL and testbench

- Produces the NIST SP 800-185 encode_string(S) = left_encode(bitlen(S)) || S as a byte stream.
- Sits directly upstream of the bytepad stage in the KMAC prefix path and builds the encoded K, N and S fields that bytepad then pads.
- Takes the string length at start, emits the left_encode header bytes, then forwards the payload bytes from an upstream valid/ready stream.
- Marks the final byte with out_last and pulses done afterwards.

---
 rtl/encode_string_stream_if.sv | 22 ++
 rtl/encode_string_stream.sv | 90 +++++++++
 tb/tb_encode_string_stream.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/encode_string_stream_if.sv
// encode_string_stream_if: control, payload-in and encoded-out stream bundle
interface encode_string_stream_if #(parameter int LEN_W = 16);
  logic             start;
  logic [LEN_W-1:0] s_len;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;
  logic             done;
  modport master (
    output start, s_len, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, busy, done
  );
  modport slave (
    input  start, s_len, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, busy, done
  );
endinterface

// File: rtl/encode_string_stream.sv
// encode_string_stream: emits left_encode(bitlen(S)) || S as a byte stream
module encode_string_stream #(
  parameter int LEN_W = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  encode_string_stream_if.slave bus
);
  localparam int BL_W = LEN_W + 3;
  localparam int MAXN = (BL_W + 7) / 8;
  localparam int NW   = $clog2(MAXN + 1);
  typedef enum logic [2:0] {IDLE, HDR_N, HDR_X, PAYLOAD, DONE} state_t;
  state_t           state_q, state_d;
  logic [BL_W-1:0]  bl_q, bl_d, bl_in;
  logic [NW-1:0]    n_q, n_d, n_in, k_q, k_d;
  logic [LEN_W-1:0] rem_q, rem_d, len;
  logic [7:0]       hdr_byte;
  logic             xfer, len_zero;
  assign bl_in    = {bus.s_len, 3'b000};
  assign len      = bl_q[BL_W-1:3];
  assign len_zero = len == '0;
  assign hdr_byte = 8'(bl_q >> {k_q, 3'b000});
  assign xfer     = bus.out_valid && bus.out_ready;
  // smallest byte count n whose range covers the captured bit length
  always_comb begin
    n_in = NW'(1);
    for (int i = 1; i < MAXN; i++)
      if ((bl_in >> (8 * i)) != '0) n_in = NW'(i + 1);
  end
  // state and datapath registers; reset aborts any encoding in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bl_q    <= '0;
      n_q     <= '0;
      k_q     <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      bl_q    <= bl_d;
      n_q     <= n_d;
      k_q     <= k_d;
      rem_q   <= rem_d;
    end
  end
  // next state: every step advances only on a completed output transfer
  always_comb begin
    state_d = state_q;
    bl_d    = bl_q;
    n_d     = n_q;
    k_d     = k_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: if (bus.start) begin
        bl_d    = bl_in;
        n_d     = n_in;
        state_d = HDR_N;
      end
      HDR_N: if (xfer) begin
        k_d     = n_q - NW'(1);
        state_d = HDR_X;
      end
      HDR_X: if (xfer) begin
        if (k_q != '0) k_d = k_q - NW'(1);
        else if (len_zero) state_d = DONE;
        else begin
          rem_d   = len;
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: if (xfer) begin
        rem_d   = rem_q - LEN_W'(1);
        state_d = rem_q == LEN_W'(1) ? DONE : PAYLOAD;
      end
      default: state_d = IDLE;
    endcase
  end
  // outputs: header bytes from registers, payload passed straight through
  always_comb begin
    bus.out_valid = state_q == HDR_N || state_q == HDR_X || (state_q == PAYLOAD && bus.in_valid);
    bus.out_data  = state_q == HDR_N ? 8'(n_q) :
                    state_q == HDR_X ? hdr_byte :
                    state_q == PAYLOAD ? bus.in_data : 8'h00;
    bus.out_last  = (state_q == HDR_X && k_q == '0 && len_zero) ||
                    (state_q == PAYLOAD && rem_q == LEN_W'(1));
    bus.in_ready  = state_q == PAYLOAD && bus.out_ready;
    bus.busy      = state_q != IDLE;
    bus.done      = state_q == DONE;
  end
endmodule

// File: tb/tb_encode_string_stream.sv
// tb_encode_string_stream: randomized stream checks against a byte-queue model of encode_string
module tb_encode_string_stream;
  localparam int LW = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  encode_string_stream_if #(.LEN_W(LW)) bus ();
  encode_string_stream #(.LEN_W(LW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  int total = 0;
  int passed = 0;
  int fails = 0;
  int hn = 0;
  logic [7:0] pay[$];
  logic [7:0] exq[$];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic void fill(input int len);
    pay = {};
    for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
  endfunction
  function automatic void build_exp(input int len);
    int bl = len * 8;
    int n = bl < 256 ? 1 : (bl < 65536 ? 2 : 3);
    exq = {};
    exq.push_back(8'(n));
    for (int i = n - 1; i >= 0; i--) exq.push_back(8'(bl >> (8 * i)));
    foreach (pay[i]) exq.push_back(pay[i]);
    hn = n + 1;
  endfunction
  task automatic run_op(input int len, input int rp, input int vp, input int abort_at, input bit start_in_done);
    int oi = 0;
    int pi = 0;
    int cyc = 0;
    bit held = 0;
    bit xo, xi;
    logic [7:0] hd = '0;
    build_exp(len);
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.s_len = LW'(len);
    @(negedge clk);
    bus.start = 1'b0;
    bus.s_len = LW'($urandom);
    while (oi < exq.size()) begin
      if (abort_at >= 0 && oi == abort_at) break;
      if (cyc++ > 4000) begin
        chk("timeout", oi, exq.size());
        break;
      end
      bus.out_ready = $urandom_range(99) < rp;
      if (!bus.in_valid) bus.in_valid = pi < pay.size() && $urandom_range(99) < vp;
      bus.in_data = pi < pay.size() ? pay[pi] : 8'h00;
      #1;
      if (held) chk("stable", bus.out_data, hd);
      chk("in_ready", bus.in_ready, oi >= hn && bus.out_ready);
      chk("out_valid", bus.out_valid, oi < hn || bus.in_valid);
      chk("busy", bus.busy, 1);
      chk("done_early", bus.done, 0);
      xo = bus.out_valid && bus.out_ready;
      xi = bus.in_valid && bus.in_ready;
      if (xo) begin
        chk("out_data", bus.out_data, exq[oi]);
        chk("out_last", bus.out_last, oi == exq.size() - 1);
        oi++;
      end
      held = bus.out_valid && !bus.out_ready;
      hd = bus.out_data;
      @(negedge clk);
      if (xi) begin
        pi++;
        bus.in_valid = 1'b0;
      end
    end
    if (abort_at < 0) begin
      #1;
      chk("done_pulse", bus.done, 1);
      chk("done_valid", bus.out_valid, 0);
      chk("done_busy", bus.busy, 1);
      if (start_in_done) begin
        bus.start = 1'b1;
        bus.s_len = LW'(3);
      end
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      chk("done_clear", bus.done, 0);
      chk("idle_busy", bus.busy, 0);
      @(negedge clk);
      #1;
      chk("still_idle", bus.busy, 0);
      chk("idle_valid", bus.out_valid, 0);
    end
  endtask
  task automatic do_reset();
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h5A;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("rst_no_done", bus.done, 0);
    end
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_done", bus.done, 0);
    chk("post_rst_busy", bus.busy, 0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.s_len = '0;
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_busy", bus.busy, 0);
    chk("reset_valid", bus.out_valid, 0);
    chk("reset_data", bus.out_data, 0);
    chk("reset_done", bus.done, 0);
    rst_n = 1'b1;
    pay = '{8'hAA, 8'hBB, 8'hCC};
    run_op(3, 100, 100, -1, 1);
    pay = {};
    run_op(0, 100, 100, -1, 0);
    fill(32);
    run_op(32, 100, 100, -1, 0);
    fill(10);
    run_op(65535, 100, 100, 7, 0);
    do_reset();
    for (int r = 0; r < 4; r++) begin
      fill(5);
      run_op(5, 50, 60, -1, 0);
    end
    fill(5);
    run_op(5, 100, 100, 4, 0);
    do_reset();
    fill(1);
    run_op(1, 100, 100, -1, 0);
    for (int r = 0; r < 6; r++) begin
      int len = $urandom_range(0, 40);
      fill(len);
      run_op(len, 70, 70, -1, 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
